// File: rtl/ama_riscv_inst_encoder.sv
// RV32 instruction encoder feeding a DEPTH-entry FIFO toward the core's injection port.
// Define AMA_RISCV_ENC_RANGE_CHECK_EN to reject requests whose immediates do not fit their format.
module ama_riscv_inst_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_fmt,
  input  logic [6:0]               req_opc7,
  input  logic [4:0]               req_rd,
  input  logic [4:0]               req_rs1,
  input  logic [4:0]               req_rs2,
  input  logic [2:0]               req_fn3,
  input  logic [6:0]               req_fn7,
  input  logic [31:0]              req_imm,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     enc_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   inst_q, inst_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  logic [31:0]   enc_word;
  logic          fmt_rsvd;
  logic          range_err;
  logic          accept, push, pop;
  logic [31:0]   head_word;

  // Field packing; the immediate arrives unswizzled, as the decoder would produce it
  always_comb begin
    enc_word = '0;
    fmt_rsvd = 1'b0;
    case (req_fmt)
      FMT_R: enc_word = {req_fn7, req_rs2, req_rs1, req_fn3, req_rd, req_opc7};
      FMT_I: enc_word = {req_imm[11:0], req_rs1, req_fn3, req_rd, req_opc7};
      FMT_S: enc_word = {req_imm[11:5], req_rs2, req_rs1, req_fn3, req_imm[4:0], req_opc7};
      FMT_B: enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_fn3,
                         req_imm[4:1], req_imm[11], req_opc7};
      FMT_U: enc_word = {req_imm[31:12], req_rd, req_opc7};
      FMT_J: enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                         req_rd, req_opc7};
      default: fmt_rsvd = 1'b1;
    endcase
  end

`ifdef AMA_RISCV_ENC_RANGE_CHECK_EN
  // Upper immediate bits must be a pure sign extension of the encodable field
  always_comb begin
    range_err = 1'b0;
    case (req_fmt)
      FMT_I, FMT_S: range_err = !((&req_imm[31:11]) || !(|req_imm[31:11]));
      FMT_B:        range_err = !((&req_imm[31:12]) || !(|req_imm[31:12])) || req_imm[0];
      FMT_J:        range_err = !((&req_imm[31:20]) || !(|req_imm[31:20])) || req_imm[0];
      FMT_U:        range_err = |req_imm[11:0];
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign accept = req_valid & ready_q;
  assign push   = accept & !fmt_rsvd & !range_err;
  assign pop    = valid_q & inst_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    inst_d    = inst_q;
    err_d     = err_q | (accept & (fmt_rsvd | range_err));
    head_word = '0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push && pop) cnt_d = cnt_q - CW'(1);
      // New head may be the word being written this edge
      head_word = (push && (wr_ptr_q == rd_ptr_d)) ? enc_word : mem_q[rd_ptr_d];
      if (cnt_d != '0) inst_d = head_word;
    end
    valid_d = (cnt_d != '0);
    ready_d = (cnt_d != CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      if (push && !flush) mem_q[wr_ptr_q] <= enc_word;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = ready_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign fifo_cnt   = cnt_q;
  assign enc_err    = err_q;

endmodule

// File: tb/tb_ama_riscv_inst_encoder.sv
// Directed bench for ama_riscv_inst_encoder: encoding table plus FIFO, flush, reset and error sequences.
module tb_ama_riscv_inst_encoder;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opc7;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [2:0]  req_fn3;
  logic [6:0]  req_fn7;
  logic [31:0] req_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic        enc_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ama_riscv_inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_opc7(req_opc7), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_fn3(req_fn3),
    .req_fn7(req_fn7), .req_imm(req_imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .fifo_cnt(fifo_cnt), .enc_err(enc_err)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] fn3,
                         input logic [6:0] fn7, input logic [31:0] imm);
    req_valid = 1'b1;
    req_fmt   = fmt;
    req_opc7  = opc;
    req_rd    = rd;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_fn3   = fn3;
    req_fn7   = fn7;
    req_imm   = imm;
  endtask

  // addi x1, x0, k
  function automatic logic [31:0] w_addi(input int k);
    return 32'h0000_0093 | (32'(k) << 20);
  endfunction

  task automatic req_addi(input int k);
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " cnt"},        32'(fifo_cnt),   32'd0);
    chk({tag, " inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, " inst"},       inst,            32'd0);
    chk({tag, " req_ready"},  32'(req_ready),  32'd1);
    chk({tag, " enc_err"},    32'(enc_err),    32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //              fmt   opc    rd  rs1 rs2 fn3 fn7     imm            expected
    vecs[0] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'h0000_0005, 32'h0050_0093};
    vecs[1] = '{3'd2, 7'h23, 5'd0, 5'd3, 5'd2,  3'd2, 7'h00, 32'h0000_0008, 32'h0021_A423};
    vecs[2] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0,  3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7};
    vecs[3] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3};
    vecs[4] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF};
    vecs[5] = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2,  3'd0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3};
    vecs[6] = '{3'd1, 7'h13, 5'd2, 5'd2, 5'd31, 3'd0, 7'h7F, 32'hFFFF_FFFF, 32'hFFF1_0113};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; inst_ready = 1'b0;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    req_valid = 1'b0;
    #12;
    chk_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // Encoding table: each word appears one cycle after accept, then is popped
    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].fmt, vecs[i].opc, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
              vecs[i].fn3, vecs[i].fn7, vecs[i].imm);
      tick();
      req_valid = 1'b0;
      chk($sformatf("vec%0d inst_valid", i), 32'(inst_valid), 32'd1);
      chk($sformatf("vec%0d inst", i), inst, vecs[i].exp);
      chk($sformatf("vec%0d cnt", i), 32'(fifo_cnt), 32'd1);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk($sformatf("vec%0d drained", i), 32'(inst_valid), 32'd0);
    end
    chk("table enc_err", 32'(enc_err), 32'd0);

    // Out-of-range I immediate
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    tick();
    req_valid = 1'b0;
`ifdef AMA_RISCV_ENC_RANGE_CHECK_EN
    chk("range cnt", 32'(fifo_cnt), 32'd0);
    chk("range enc_err", 32'(enc_err), 32'd1);
`else
    chk("trunc inst", inst, 32'h8000_0093);
    chk("trunc cnt", 32'(fifo_cnt), 32'd1);
    chk("trunc enc_err", 32'(enc_err), 32'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
`endif

    do_reset();

    // Reserved format is consumed without a push
    set_req(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("rsvd enc_err", 32'(enc_err), 32'd1);
    chk("rsvd cnt", 32'(fifo_cnt), 32'd0);
    chk("rsvd inst_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("rsvd sticky", 32'(enc_err), 32'd1);

    do_reset();

    // Fill, backpressure, pop-frees-slot, push+pop, ordering across pointer wrap
    for (int k = 0; k < 4; k++) begin
      req_addi(k);
      tick();
    end
    req_addi(4);
    chk("full cnt", 32'(fifo_cnt), 32'd4);
    chk("full req_ready", 32'(req_ready), 32'd0);
    chk("full head", inst, w_addi(0));
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("pop1 cnt", 32'(fifo_cnt), 32'd3);
    chk("pop1 req_ready", 32'(req_ready), 32'd1);
    chk("pop1 head", inst, w_addi(1));
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    req_addi(5);
    chk("pushpop cnt", 32'(fifo_cnt), 32'd3);
    chk("pushpop head", inst, w_addi(2));
    tick();
    req_valid = 1'b0;
    chk("refill cnt", 32'(fifo_cnt), 32'd4);
    chk("refill req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("stall hold", inst, w_addi(2));
    for (int j = 2; j < 6; j++) begin
      chk($sformatf("order%0d valid", j), 32'(inst_valid), 32'd1);
      chk($sformatf("order%0d inst", j), inst, w_addi(j));
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
    end
    chk("empty valid", 32'(inst_valid), 32'd0);
    chk("empty cnt", 32'(fifo_cnt), 32'd0);
    chk("empty hold", inst, w_addi(5));

    // Flush beats same-cycle push and pop
    for (int k = 10; k < 13; k++) begin
      req_addi(k);
      tick();
    end
    req_valid = 1'b0;
    chk("preflush cnt", 32'(fifo_cnt), 32'd3);
    flush = 1'b1;
    inst_ready = 1'b1;
    req_addi(13);
    tick();
    flush = 1'b0;
    inst_ready = 1'b0;
    req_valid = 1'b0;
    chk("flush cnt", 32'(fifo_cnt), 32'd0);
    chk("flush valid", 32'(inst_valid), 32'd0);
    chk("flush req_ready", 32'(req_ready), 32'd1);
    req_addi(14);
    tick();
    req_valid = 1'b0;
    chk("postflush head", inst, w_addi(14));
    chk("postflush cnt", 32'(fifo_cnt), 32'd1);

    // Reset mid-burst with a reserved-format error pending
    set_req(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    chk("midburst err", 32'(enc_err), 32'd1);
    req_addi(20);
    tick();
    req_addi(21);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_reset("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
